alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
// Initiator side of the ALU_16bit start/op/A/B -> Z_low/Z_high/valid interface.
// Accepts ALU commands over a valid/ready stream and buffers them in a small FIFO.
// Issues one command at a time to the ALU and waits for the ALU valid.
// Returns each result, with an error flag, over a valid/ready result stream.
// PARAMETERS
// FIFO_DEPTH  4   command FIFO entries; power of 2, >= 2
// TIMEOUT     64  max cycles spent in WAIT before the command is declared failed
// PORTS
// clk        in   1   clock, rising edge
// rst        in   1   asynchronous, active-low reset
// cmd_valid  in   1   command offered
// cmd_ready  out  1   command accepted when cmd_valid & cmd_ready
// cmd_op     in   4   ALU opcode; 0000-1101 legal, 1110/1111 illegal
// cmd_a      in   16  operand A (signed)
// cmd_b      in   16  operand B (signed)
// alu_start  out  1   one-cycle start pulse to the ALU
// alu_op     out  4   opcode to the ALU; 4'b1111 whenever not in ISSUE/WAIT
// alu_a      out  16  operand A to the ALU
// alu_b      out  16  operand B to the ALU
// alu_z_low  in   16  ALU Z_low
// alu_z_high in   16  ALU Z_high
// alu_valid  in   1   ALU valid
// res_valid  out  1   result offered
// res_ready  in   1   result consumed when res_valid & res_ready
// res_low    out  16  captured Z_low, or 0 on error
// res_high   out  16  captured Z_high, or 0 on error
// res_op     out  4   opcode of this result
// res_err    out  1   1 = illegal opcode or timeout
// fifo_cnt   out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
// BEHAVIOUR
// Reset (rst=0, async):
// - FIFO emptied; state set to IDLE.
// - alu_start=0, alu_op=4'b1111, alu_a=alu_b=0.
// - res_valid=0, res_low=res_high=0, res_op=0, res_err=0, fifo_cnt=0.
// - The active command is discarded. Reset mid-command leaves no partial state.
// FIFO:
// - cmd_ready = (fifo_cnt != FIFO_DEPTH). It is combinational on the count only.
// - Push on cmd handshake. Pop on entry to ISSUE.
// - Push and pop in the same cycle leave fifo_cnt unchanged. Pointers wrap modulo FIFO_DEPTH.
// States:
// IDLE:
// - If the FIFO is non-empty, pop the head.
// - Go to ISSUE if the opcode is legal.
// - Go to RESP if the opcode is illegal: res_err=1, res_low=res_high=0, and the ALU is untouched.
// ISSUE (exactly 1 cycle):
// - alu_start=1; alu_op, alu_a and alu_b carry the command.
// - Clear the timeout counter, then go to WAIT.
// WAIT:
// - alu_start=0; alu_op, alu_a and alu_b are held stable.
// - On alu_valid, capture z_low/z_high into res_low/res_high (res_err=0) and go to RESP.
// - Single-cycle ops assert alu_valid in the first WAIT cycle. MUL and DIV take multi-cycle latency.
// - DIV with B=0 completes in the first WAIT cycle. Its Z value is passed through unchanged.
// - If the counter reaches TIMEOUT-1 with no alu_valid: res_err=1, res_low=res_high=0, go to RESP.
// RESP:
// - res_valid=1; alu_op=4'b1111; res_* stay stable until the handshake.
// - On res_ready, go to ISSUE or RESP (by the head opcode) if the FIFO is non-empty, else to IDLE.
// Other rules:
// - alu_valid outside WAIT is ignored.
// - res_op equals the opcode of the command that produced the result.
// - Results are returned strictly in command order.
// - Best throughput for single-cycle ops is 3 cycles per command: ISSUE, WAIT, RESP with res_ready=1.
// TESTING
// - Reset, then push ADD A=5 B=-7 -> alu_start high 1 cycle; res_low=-2, res_high=16'hFFFF, err=0.
// - Push MUL A=300 B=-200 with an ALU model of N-cycle latency -> res_high:res_low=-60000; alu_op/a/b stable through WAIT.
// - Push ops 1110 then AND 16'hF0F0&16'h0FF0 -> result 1: err=1 with no alu_start; result 2: 16'h00F0.
// - ALU model never asserts valid -> res_err=1 exactly TIMEOUT cycles after ISSUE; the next command issues normally.
// - Hold res_ready=0 and push FIFO_DEPTH+1 commands -> cmd_ready drops at fifo_cnt=FIFO_DEPTH; order preserved on drain.
// - Assert rst during WAIT of a DIV -> all outputs at reset values immediately; a stray later alu_valid is ignored.

Source files
------------

// File: rtl/alu_cmd_sequencer_if.sv
// Signal bundle between the command source, the ALU and the result sink of alu_cmd_sequencer.
// master = the sequencer, slave = the environment around it.
interface alu_cmd_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic        alu_start;
  logic [3:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_z_low;
  logic [15:0] alu_z_high;
  logic        alu_valid;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_low;
  logic [15:0] res_high;
  logic [3:0]  res_op;
  logic        res_err;

  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_z_low, alu_z_high, alu_valid, res_ready,
    output cmd_ready, alu_start, alu_op, alu_a, alu_b, res_valid, res_low, res_high, res_op, res_err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_a, cmd_b, alu_z_low, alu_z_high, alu_valid, res_ready,
    input  cmd_ready, alu_start, alu_op, alu_a, alu_b, res_valid, res_low, res_high, res_op, res_err
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands in a FIFO, issues them one at a time to a start/valid ALU and
// returns each result (or an illegal-op / timeout error) in command order.
module alu_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  alu_cmd_sequencer_if.master         bus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  cmd_t          fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  cmd_t          head, cur;
  state_t        state, state_nxt;
  logic [TW-1:0] tmo_cnt;
  logic          push, pop, empty, head_ok, active, tmo_hit;
  logic [15:0]   res_low, res_high;
  logic [3:0]    res_op;
  logic          res_err;

  assign bus.cmd_ready = (fifo_cnt != CW'(FIFO_DEPTH));
  assign push    = bus.cmd_valid & bus.cmd_ready;
  assign empty   = (fifo_cnt == '0);
  assign head    = fifo_mem[rd_ptr];
  assign head_ok = (head.op <= 4'd13);
  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = head_ok ? ISSUE : RESP;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (bus.alu_valid || tmo_hit) state_nxt = RESP;
      end
      RESP: begin
        if (bus.res_ready) begin
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = head_ok ? ISSUE : RESP;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Active command, timeout counter and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur      <= '0;
      tmo_cnt  <= '0;
      res_low  <= '0;
      res_high <= '0;
      res_op   <= '0;
      res_err  <= 1'b0;
    end else begin
      if (pop) begin
        cur <= head;
        if (!head_ok) begin
          res_low  <= '0;
          res_high <= '0;
          res_op   <= head.op;
          res_err  <= 1'b1;
        end
      end
      if (state == ISSUE)     tmo_cnt <= '0;
      else if (state == WAIT) tmo_cnt <= tmo_cnt + TW'(1);
      if (state == WAIT) begin
        if (bus.alu_valid) begin
          res_low  <= bus.alu_z_low;
          res_high <= bus.alu_z_high;
          res_op   <= cur.op;
          res_err  <= 1'b0;
        end else if (tmo_hit) begin
          res_low  <= '0;
          res_high <= '0;
          res_op   <= cur.op;
          res_err  <= 1'b1;
        end
      end
    end
  end

  assign active        = (state == ISSUE) || (state == WAIT);
  assign bus.alu_start = (state == ISSUE);
  assign bus.alu_op    = active ? cur.op : 4'b1111;
  assign bus.alu_a     = active ? cur.a  : 16'h0000;
  assign bus.alu_b     = active ? cur.b  : 16'h0000;

  assign bus.res_valid = (state == RESP);
  assign bus.res_low   = res_low;
  assign bus.res_high  = res_high;
  assign bus.res_op    = res_op;
  assign bus.res_err   = res_err;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a behavioural ALU (ADD=0 SUB=1 MUL=2 DIV=3 AND=4 assumed)
// plus an expected-result queue filled at command push and drained at result handshake.
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 64;
  localparam int MUL_LAT    = 4;
  localparam int DIV_LAT    = 6;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_DIV = 4'd3, OP_AND = 4'd4;

  typedef struct packed {
    logic [15:0] high;
    logic [15:0] low;
    logic [3:0]  op;
    logic        err;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [$clog2(FIFO_DEPTH):0] fifo_cnt;

  alu_cmd_sequencer_if bus();

  alu_cmd_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .bus(bus.master), .fifo_cnt(fifo_cnt)
  );

  always #5 clk = ~clk;

  res_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   start_cnt = 0;

  logic        model_valid = 1'b0;
  logic        stray_valid = 1'b0;
  logic [31:0] model_z = 32'h0;
  bit          alu_never = 1'b0;
  bit          pend = 1'b0;
  int          left = 0;

  assign bus.alu_valid  = model_valid | stray_valid;
  assign bus.alu_z_low  = model_z[15:0];
  assign bus.alu_z_high = model_z[31:16];

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] ax, bx;
    ax = {{16{a[15]}}, a};
    bx = {{16{b[15]}}, b};
    case (op)
      OP_ADD:  return ax + bx;
      OP_SUB:  return ax - bx;
      OP_MUL:  return $signed(ax) * $signed(bx);
      OP_DIV:  return (b == 16'h0) ? {a, 16'hFFFF} : {16'($signed(a) % $signed(b)), 16'($signed(a) / $signed(b))};
      OP_AND:  return {16'h0000, a & b};
      default: return 32'h0;
    endcase
  endfunction

  // ALU model: latched on the start pulse, answers after its latency; never answers in alu_never mode.
  always @(negedge clk) begin
    if (bus.alu_start) start_cnt++;
    if (model_valid) begin
      model_valid = 1'b0;
      pend = 1'b0;
    end else if (bus.alu_start) begin
      pend    = !alu_never;
      model_z = alu_ref(bus.alu_op, bus.alu_a, bus.alu_b);
      left    = (bus.alu_op == OP_MUL) ? MUL_LAT - 1 :
                (bus.alu_op == OP_DIV && bus.alu_b != 16'h0) ? DIV_LAT - 1 : 0;
    end else if (pend) begin
      if (left == 0) model_valid = 1'b1;
      else left--;
    end
  end

  task automatic push_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input res_t exp);
    int n = 0;
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b;
    while (!bus.cmd_ready && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (!bus.cmd_ready) begin
      errors++;
      $display("FAIL push_accept: cmd_ready=0 after %0d cycles, required 1", n);
    end else begin
      sb.push_back(exp);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic get_result(output res_t r, output bit got);
    int n = 0;
    bus.res_ready = 1'b1;
    while (!bus.res_valid && n < 200) begin @(negedge clk); n++; end
    got = bus.res_valid;
    r = {bus.res_high, bus.res_low, bus.res_op, bus.res_err};
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  function automatic res_t sb_pop();
    if (sb.size() == 0) return '0;
    return sb.pop_front();
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.alu_start, bus.alu_op, bus.alu_a, bus.alu_b} !== {1'b0, 4'hF, 32'h0}) begin
      errors++;
      $display("FAIL reset_alu: start/op/a/b=%b/%h/%h/%h required 0/f/0000/0000", bus.alu_start, bus.alu_op, bus.alu_a, bus.alu_b);
    end
    checks++;
    if ({bus.res_valid, bus.res_low, bus.res_high, bus.res_op, bus.res_err} !== 38'h0) begin
      errors++;
      $display("FAIL reset_res: valid/low/high/op/err=%b/%h/%h/%h/%b required all 0",
               bus.res_valid, bus.res_low, bus.res_high, bus.res_op, bus.res_err);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (fifo_cnt !== 3'd0 || bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_fifo: fifo_cnt=%0d cmd_ready=%b required 0/1", fifo_cnt, bus.cmd_ready);
    end
  endtask

  task automatic test_add();
    res_t r, e; bit got; int n = 0, starts = 0;
    logic [15:0] sa = 16'h0, sbv = 16'h0;
    push_cmd(OP_ADD, 16'd5, 16'hFFF9, {16'hFFFF, 16'hFFFE, OP_ADD, 1'b0});
    while (!bus.res_valid && n < 20) begin
      if (bus.alu_start) begin starts++; sa = bus.alu_a; sbv = bus.alu_b; end
      @(negedge clk); n++;
    end
    checks++;
    if (starts != 1 || sa !== 16'd5 || sbv !== 16'hFFF9) begin
      errors++;
      $display("FAIL add_start: %0d pulses a=%h b=%h, required 1 pulse a=0005 b=fff9", starts, sa, sbv);
    end
    get_result(r, got); e = sb_pop();
    checks++;
    if (!got || r !== e) begin errors++; $display("FAIL add_result: got %h (valid %b) required %h", r, got, e); end
  endtask

  task automatic test_mul();
    res_t r, e; bit got; int n = 0, w = 0;
    push_cmd(OP_MUL, 16'd300, 16'hFF38, {16'hFFFF, 16'h15A0, OP_MUL, 1'b0});
    while (!bus.alu_start && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    while (!bus.res_valid && w < 100) begin
      checks++;
      if ({bus.alu_start, bus.alu_op, bus.alu_a, bus.alu_b} !== {1'b0, OP_MUL, 16'd300, 16'hFF38}) begin
        errors++;
        $display("FAIL mul_hold: start/op/a/b=%b/%h/%h/%h required 0/2/012c/ff38", bus.alu_start, bus.alu_op, bus.alu_a, bus.alu_b);
      end
      @(negedge clk); w++;
    end
    checks++;
    if (w != MUL_LAT) begin errors++; $display("FAIL mul_latency: %0d wait cycles required %0d", w, MUL_LAT); end
    get_result(r, got); e = sb_pop();
    checks++;
    if (!got || r !== e) begin errors++; $display("FAIL mul_result: got %h (valid %b) required %h", r, got, e); end
  endtask

  task automatic test_div_zero();
    res_t r, e; bit got; int n = 0, w = 0;
    push_cmd(OP_DIV, 16'd9, 16'd0, {16'h0009, 16'hFFFF, OP_DIV, 1'b0});
    while (!bus.alu_start && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    while (!bus.res_valid && w < 100) begin @(negedge clk); w++; end
    checks++;
    if (w != 1) begin errors++; $display("FAIL div0_latency: %0d wait cycles required 1", w); end
    get_result(r, got); e = sb_pop();
    checks++;
    if (!got || r !== e) begin errors++; $display("FAIL div0_result: got %h (valid %b) required %h", r, got, e); end
  endtask

  task automatic test_illegal();
    res_t r, e; bit got; int n = 0, s0;
    s0 = start_cnt;
    push_cmd(4'hE, 16'h1234, 16'h5678, {16'h0000, 16'h0000, 4'hE, 1'b1});
    push_cmd(OP_AND, 16'hF0F0, 16'h0FF0, {16'h0000, 16'h00F0, OP_AND, 1'b0});
    while (!bus.res_valid && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (start_cnt != s0 || bus.alu_op !== 4'hF) begin
      errors++;
      $display("FAIL illegal_no_start: %0d pulses alu_op=%h required 0 pulses op=f", start_cnt - s0, bus.alu_op);
    end
    get_result(r, got); e = sb_pop();
    checks++;
    if (!got || r !== e) begin errors++; $display("FAIL illegal_result: got %h (valid %b) required %h", r, got, e); end
    get_result(r, got); e = sb_pop();
    checks++;
    if (!got || r !== e) begin errors++; $display("FAIL and_result: got %h (valid %b) required %h", r, got, e); end
    checks++;
    if (start_cnt != s0 + 1) begin errors++; $display("FAIL and_start: %0d pulses required 1", start_cnt - s0); end
  endtask

  task automatic test_timeout();
    res_t r, e; bit got; int n = 0, w = 0;
    alu_never = 1'b1;
    push_cmd(OP_ADD, 16'd1, 16'd1, {16'h0000, 16'h0000, OP_ADD, 1'b1});
    while (!bus.alu_start && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    while (!bus.res_valid && w < 200) begin @(negedge clk); w++; end
    checks++;
    if (w != TIMEOUT) begin errors++; $display("FAIL timeout_cycles: %0d wait cycles required %0d", w, TIMEOUT); end
    get_result(r, got); e = sb_pop();
    checks++;
    if (!got || r !== e) begin errors++; $display("FAIL timeout_result: got %h (valid %b) required %h", r, got, e); end
    alu_never = 1'b0;
    push_cmd(OP_SUB, 16'd10, 16'd3, {16'h0000, 16'h0007, OP_SUB, 1'b0});
    get_result(r, got); e = sb_pop();
    checks++;
    if (!got || r !== e) begin errors++; $display("FAIL after_timeout: got %h (valid %b) required %h", r, got, e); end
  endtask

  task automatic test_full();
    res_t r, e; bit got;
    for (int i = 0; i < FIFO_DEPTH + 1; i++)
      push_cmd(OP_ADD, 16'(i + 1), 16'(16 * i), {16'h0000, 16'(i + 1 + 16 * i), OP_ADD, 1'b0});
    repeat (4) @(negedge clk);
    checks++;
    if (fifo_cnt !== 3'(FIFO_DEPTH) || bus.cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_level: fifo_cnt=%0d cmd_ready=%b required %0d/0", fifo_cnt, bus.cmd_ready, FIFO_DEPTH);
    end
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_ADD; bus.cmd_a = 16'hDEAD; bus.cmd_b = 16'h0;
    repeat (3) @(negedge clk);
    bus.cmd_valid = 1'b0;
    checks++;
    if (fifo_cnt !== 3'(FIFO_DEPTH)) begin
      errors++;
      $display("FAIL full_block: fifo_cnt=%0d required %0d", fifo_cnt, FIFO_DEPTH);
    end
    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
      get_result(r, got); e = sb_pop();
      checks++;
      if (!got || r !== e) begin errors++; $display("FAIL drain_%0d: got %h (valid %b) required %h", i, r, got, e); end
    end
    checks++;
    if (fifo_cnt !== 3'd0) begin errors++; $display("FAIL drain_empty: fifo_cnt=%0d required 0", fifo_cnt); end
  endtask

  task automatic test_back_to_back();
    res_t r, e; int n = 0, k = 0; int idx [3];
    for (int i = 0; i < 3; i++)
      push_cmd(OP_ADD, 16'(i + 1), 16'(256 * i), {16'h0000, 16'(i + 1 + 256 * i), OP_ADD, 1'b0});
    while (!bus.res_valid && n < 20) begin @(negedge clk); n++; end
    bus.res_ready = 1'b1;
    for (int c = 0; c < 30 && k < 3; c++) begin
      if (bus.res_valid) begin
        idx[k] = c;
        r = {bus.res_high, bus.res_low, bus.res_op, bus.res_err}; e = sb_pop();
        checks++;
        if (r !== e) begin errors++; $display("FAIL b2b_result_%0d: got %h required %h", k, r, e); end
        k++;
      end
      @(negedge clk);
    end
    bus.res_ready = 1'b0;
    checks++;
    if (k != 3 || idx[1] - idx[0] != 3 || idx[2] - idx[1] != 3) begin
      errors++;
      $display("FAIL b2b_rate: %0d results at cycles %0d,%0d,%0d required 3 results 3 cycles apart", k, idx[0], idx[1], idx[2]);
    end
  endtask

  task automatic test_reset_mid();
    res_t r, e; bit got; int n = 0, bad = 0;
    push_cmd(OP_DIV, 16'd100, 16'd7, '0);
    while (!bus.alu_start && n < 20) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    sb.delete();
    checks++;
    if ({bus.alu_start, bus.alu_op, bus.alu_a, bus.alu_b, bus.res_valid, bus.res_low, bus.res_high,
         bus.res_op, bus.res_err, fifo_cnt, bus.cmd_ready} !== {1'b0, 4'hF, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset: start=%b op=%h a=%h b=%h rv=%b lo=%h hi=%h rop=%h err=%b cnt=%0d rdy=%b required reset values",
               bus.alu_start, bus.alu_op, bus.alu_a, bus.alu_b, bus.res_valid, bus.res_low, bus.res_high,
               bus.res_op, bus.res_err, fifo_cnt, bus.cmd_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    stray_valid = 1'b1;
    @(negedge clk);
    stray_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (bus.res_valid || bus.alu_start || bus.alu_op !== 4'hF) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stray_valid: %0d active cycles after reset required 0", bad); end
    push_cmd(OP_SUB, 16'd3, 16'd10, {16'hFFFF, 16'hFFF9, OP_SUB, 1'b0});
    get_result(r, got); e = sb_pop();
    checks++;
    if (!got || r !== e) begin errors++; $display("FAIL post_reset: got %h (valid %b) required %h", r, got, e); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = 4'h0; bus.cmd_a = 16'h0; bus.cmd_b = 16'h0;
    bus.res_ready = 1'b0;
    test_reset();
    test_add();
    test_mul();
    test_div_zero();
    test_illegal();
    test_timeout();
    test_full();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
